// File: rtl/rob_commit.sv
// rob_commit: reorder buffer that allocates up to ALLOC_WIDTH instructions per
// cycle, accepts out-of-order writebacks and retires in program order up to
// COMMIT_WIDTH per cycle. A faulting instruction reached by the retire scan
// drains the buffer and raises a one-cycle flush toward fetch.
module rob_commit #(
  parameter int ROB_DEPTH    = 16,
  parameter int ALLOC_WIDTH  = 2,
  parameter int COMMIT_WIDTH = 2,
  parameter int WB_PORTS     = 2,
  parameter int DATA_W       = 64,
  parameter int PC_W         = 64,
  parameter logic [PC_W-1:0] EXC_VECTOR = PC_W'(12'h100),
  localparam int IDX_W       = $clog2(ROB_DEPTH)
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_flush,
  input  logic [ALLOC_WIDTH-1:0]         i_alloc_valid,
  input  logic [ALLOC_WIDTH*PC_W-1:0]    i_alloc_pc,
  input  logic [ALLOC_WIDTH*5-1:0]       i_alloc_rd,
  input  logic [ALLOC_WIDTH-1:0]         i_alloc_wen,
  output logic                           o_alloc_ready,
  output logic [ALLOC_WIDTH*IDX_W-1:0]   o_alloc_idx,
  input  logic [WB_PORTS-1:0]            i_wb_valid,
  input  logic [WB_PORTS*IDX_W-1:0]      i_wb_idx,
  input  logic [WB_PORTS*DATA_W-1:0]     i_wb_data,
  input  logic [WB_PORTS-1:0]            i_wb_exc,
  output logic [COMMIT_WIDTH-1:0]        o_commit_valid,
  output logic [COMMIT_WIDTH*5-1:0]      o_commit_rd,
  output logic [COMMIT_WIDTH-1:0]        o_commit_wen,
  output logic [COMMIT_WIDTH*DATA_W-1:0] o_commit_data,
  output logic                           o_flush,
  output logic [PC_W-1:0]                o_redirect_pc,
  output logic [PC_W-1:0]                o_epc,
  output logic [IDX_W:0]                 o_count
);

  // Number of set lanes in an allocation group.
  function automatic logic [IDX_W:0] popcount(input logic [ALLOC_WIDTH-1:0] v);
    logic [IDX_W:0] n;
    n = '0;
    for (int i = 0; i < ALLOC_WIDTH; i++) begin
      n = n + (IDX_W+1)'(v[i]);
    end
    return n;
  endfunction

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [IDX_W:0]       head_r;
  logic [IDX_W:0]       tail_r;
  logic [ROB_DEPTH-1:0] done_r;
  logic [ROB_DEPTH-1:0] exc_r;
  logic [ROB_DEPTH-1:0] wen_r;
  logic [4:0]           rd_r   [ROB_DEPTH];
  logic [PC_W-1:0]      pc_r   [ROB_DEPTH];
  logic [DATA_W-1:0]    data_r [ROB_DEPTH];
  logic                 flush_r;
  logic [PC_W-1:0]      redirect_r;
  logic [PC_W-1:0]      epc_r;

  logic [IDX_W-1:0]     head_idx_s;
  logic [IDX_W-1:0]     tail_idx_s;
  logic [IDX_W:0]       count_s;
  logic [IDX_W:0]       free_s;
  logic [IDX_W:0]       alloc_n_s;
  logic [IDX_W:0]       tail_next_s;
  logic                 alloc_fire_s;
  logic [ALLOC_WIDTH-1:0] alloc_we_s;
  logic [IDX_W-1:0]     scan_idx_s [COMMIT_WIDTH];
  logic [IDX_W-1:0]     wb_off_s   [WB_PORTS];
  logic [WB_PORTS-1:0]  wb_ok_s;
  logic [IDX_W:0]       retire_n_s;
  logic                 exc_hit_s;
  logic [PC_W-1:0]      exc_pc_s;
  logic                 run_s;

  assign head_idx_s    = head_r[IDX_W-1:0];
  assign tail_idx_s    = tail_r[IDX_W-1:0];
  assign count_s       = tail_r - head_r;
  assign free_s        = (IDX_W+1)'(ROB_DEPTH) - count_s;
  assign o_count       = count_s;
  // Free space counts only entries already released; same-cycle retirement is not credited.
  assign o_alloc_ready = (free_s >= (IDX_W+1)'(ALLOC_WIDTH));
  assign alloc_n_s     = popcount(i_alloc_valid);
  // No allocation under an external flush or while our own flush pulse is out.
  assign alloc_fire_s  = o_alloc_ready & (|i_alloc_valid) & ~i_flush & ~flush_r;
  assign tail_next_s   = alloc_fire_s ? (tail_r + alloc_n_s) : tail_r;
  assign o_flush       = flush_r;
  assign o_redirect_pc = redirect_r;
  assign o_epc         = epc_r;

  // Per-lane allocation slots and write strobes.
  always_comb begin
    o_alloc_idx = '0;
    alloc_we_s  = '0;
    for (int k = 0; k < ALLOC_WIDTH; k++) begin
      o_alloc_idx[k*IDX_W +: IDX_W] = tail_idx_s + IDX_W'(k);
      alloc_we_s[k] = alloc_fire_s & i_alloc_valid[k];
    end
  end

  // Writebacks only land on entries between head and tail; flush drops them.
  always_comb begin
    wb_ok_s = '0;
    for (int p = 0; p < WB_PORTS; p++) begin
      wb_off_s[p] = i_wb_idx[p*IDX_W +: IDX_W] - head_idx_s;
      wb_ok_s[p]  = i_wb_valid[p] & ~i_flush & ({1'b0, wb_off_s[p]} < count_s);
    end
  end

  // Slots examined by the retire scan, oldest first.
  always_comb begin
    for (int j = 0; j < COMMIT_WIDTH; j++) begin
      scan_idx_s[j] = head_idx_s + IDX_W'(j);
    end
  end

  // In-order retire scan: stop at the first not-done entry or at a fault.
  always_comb begin
    o_commit_valid = '0;
    o_commit_rd    = '0;
    o_commit_wen   = '0;
    o_commit_data  = '0;
    retire_n_s     = '0;
    exc_hit_s      = 1'b0;
    exc_pc_s       = '0;
    run_s          = ~i_flush;
    for (int j = 0; j < COMMIT_WIDTH; j++) begin
      if (run_s && ((IDX_W+1)'(j) < count_s) && done_r[scan_idx_s[j]]) begin
        if (exc_r[scan_idx_s[j]]) begin
          exc_hit_s = 1'b1;
          exc_pc_s  = pc_r[scan_idx_s[j]];
          run_s     = 1'b0;
        end else begin
          o_commit_valid[j]             = 1'b1;
          o_commit_rd[j*5 +: 5]         = rd_r[scan_idx_s[j]];
          o_commit_wen[j]               = wen_r[scan_idx_s[j]];
          o_commit_data[j*DATA_W +: DATA_W] = data_r[scan_idx_s[j]];
          retire_n_s                    = retire_n_s + (IDX_W+1)'(1);
        end
      end else begin
        run_s = 1'b0;
      end
    end
  end

  // Pointer and flush-pulse state; faults and external flush both empty the buffer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      head_r     <= '0;
      tail_r     <= '0;
      flush_r    <= 1'b0;
      redirect_r <= '0;
      epc_r      <= '0;
    end else begin
      flush_r    <= exc_hit_s;
      redirect_r <= exc_hit_s ? EXC_VECTOR : '0;
      epc_r      <= exc_hit_s ? exc_pc_s : '0;
      tail_r     <= tail_next_s;
      if (i_flush) begin
        head_r <= tail_r;
      end else if (exc_hit_s) begin
        head_r <= tail_next_s;
      end else begin
        head_r <= head_r + retire_n_s;
      end
    end
  end

  // Completion flags: cleared on allocation, set by writeback (highest port wins).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      done_r <= '0;
      exc_r  <= '0;
    end else begin
      for (int k = 0; k < ALLOC_WIDTH; k++) begin
        if (alloc_we_s[k]) begin
          done_r[o_alloc_idx[k*IDX_W +: IDX_W]] <= 1'b0;
          exc_r[o_alloc_idx[k*IDX_W +: IDX_W]]  <= 1'b0;
        end
      end
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_ok_s[p]) begin
          done_r[i_wb_idx[p*IDX_W +: IDX_W]] <= 1'b1;
          exc_r[i_wb_idx[p*IDX_W +: IDX_W]]  <= i_wb_exc[p];
        end
      end
    end
  end

  // Payload storage; contents are only read once the done flag vouches for them.
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < ALLOC_WIDTH; k++) begin
      if (alloc_we_s[k]) begin
        pc_r[o_alloc_idx[k*IDX_W +: IDX_W]]  <= i_alloc_pc[k*PC_W +: PC_W];
        rd_r[o_alloc_idx[k*IDX_W +: IDX_W]]  <= i_alloc_rd[k*5 +: 5];
        wen_r[o_alloc_idx[k*IDX_W +: IDX_W]] <= i_alloc_wen[k];
      end
    end
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_ok_s[p]) begin
        data_r[i_wb_idx[p*IDX_W +: IDX_W]] <= i_wb_data[p*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: directed scenarios plus randomized traffic, checked every
// cycle against a queue-based model of the reorder buffer.
module tb_rob_commit;
  localparam int DEPTH = 16;
  localparam logic [63:0] D = 64'hD000_0000_0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush_in = 1'b0;
  logic [1:0]   alloc_valid = '0;
  logic [127:0] alloc_pc = '0;
  logic [9:0]   alloc_rd = '0;
  logic [1:0]   alloc_wen = '0;
  logic         alloc_ready;
  logic [7:0]   alloc_idx;
  logic [1:0]   wb_valid = '0;
  logic [7:0]   wb_idx = '0;
  logic [127:0] wb_data = '0;
  logic [1:0]   wb_exc = '0;
  logic [1:0]   commit_valid;
  logic [9:0]   commit_rd;
  logic [1:0]   commit_wen;
  logic [127:0] commit_data;
  logic         flush_out;
  logic [63:0]  redirect_pc;
  logic [63:0]  epc;
  logic [4:0]   count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rob_commit dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush_in),
    .i_alloc_valid(alloc_valid), .i_alloc_pc(alloc_pc), .i_alloc_rd(alloc_rd),
    .i_alloc_wen(alloc_wen), .o_alloc_ready(alloc_ready), .o_alloc_idx(alloc_idx),
    .i_wb_valid(wb_valid), .i_wb_idx(wb_idx), .i_wb_data(wb_data), .i_wb_exc(wb_exc),
    .o_commit_valid(commit_valid), .o_commit_rd(commit_rd), .o_commit_wen(commit_wen),
    .o_commit_data(commit_data), .o_flush(flush_out), .o_redirect_pc(redirect_pc),
    .o_epc(epc), .o_count(count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model: in-flight entries, oldest first ----------
  typedef struct {
    int          idx;
    logic [63:0] pc;
    logic [4:0]  rd;
    logic        wen;
    logic        done;
    logic        exc;
    logic [63:0] data;
  } ent_t;

  ent_t        q[$];
  int          m_tail = 0;
  logic        m_fl = 1'b0;
  logic [63:0] m_epc = '0;
  logic [1:0]  e_cv;
  int          e_ret;
  logic        e_exc;
  logic [63:0] e_pc;

  function automatic void model_scan();
    e_cv = '0; e_ret = 0; e_exc = 1'b0; e_pc = '0;
    if (!flush_in) begin
      for (int j = 0; j < 2; j++) begin
        if (j >= q.size() || !q[j].done) break;
        if (q[j].exc) begin
          e_exc = 1'b1; e_pc = q[j].pc;
          break;
        end
        e_cv[j] = 1'b1; e_ret++;
      end
    end
  endfunction

  function automatic void model_next();
    bit   rdy;
    ent_t e;
    rdy = (DEPTH - q.size()) >= 2;
    if (flush_in) begin
      q.delete();
      m_fl = 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (wb_valid[p]) begin
          foreach (q[i]) begin
            if (q[i].idx == int'(wb_idx[p*4 +: 4])) begin
              q[i].done = 1'b1; q[i].exc = wb_exc[p]; q[i].data = wb_data[p*64 +: 64];
            end
          end
        end
      end
      repeat (e_ret) void'(q.pop_front());
      if (rdy && alloc_valid != 2'b00 && !m_fl) begin
        for (int k = 0; k < 2; k++) begin
          if (alloc_valid[k]) begin
            e.idx = m_tail % DEPTH; e.pc = alloc_pc[k*64 +: 64]; e.rd = alloc_rd[k*5 +: 5];
            e.wen = alloc_wen[k]; e.done = 1'b0; e.exc = 1'b0; e.data = '0;
            q.push_back(e);
            m_tail++;
          end
        end
      end
      if (e_exc) q.delete();
      m_fl = e_exc; m_epc = e_pc;
    end
  endfunction

  // Compare process: one check pass per cycle, after inputs settle, before the edge.
  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      q.delete(); m_tail = 0; m_fl = 1'b0; m_epc = '0;
      chk("rst_count", count, 64'd0);
      chk("rst_commit_valid", commit_valid, 64'd0);
      chk("rst_flush", flush_out, 64'd0);
      chk("rst_ready", alloc_ready, 64'd1);
    end else begin
      model_scan();
      chk("count", count, 64'(q.size()));
      chk("alloc_ready", alloc_ready, 64'((DEPTH - q.size()) >= 2));
      for (int k = 0; k < 2; k++)
        chk($sformatf("alloc_idx%0d", k), alloc_idx[k*4 +: 4], 64'((m_tail + k) % DEPTH));
      chk("commit_valid", commit_valid, e_cv);
      for (int j = 0; j < 2; j++) begin
        if (e_cv[j]) begin
          chk($sformatf("commit_rd%0d", j), commit_rd[j*5 +: 5], q[j].rd);
          chk($sformatf("commit_wen%0d", j), commit_wen[j], q[j].wen);
          chk($sformatf("commit_data%0d", j), commit_data[j*64 +: 64], q[j].data);
        end else begin
          chk($sformatf("commit_wen_idle%0d", j), commit_wen[j], 64'd0);
        end
      end
      chk("o_flush", flush_out, m_fl);
      if (m_fl) begin
        chk("redirect_pc", redirect_pc, 64'h100);
        chk("epc", epc, m_epc);
      end
      model_next();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    flush_in = 1'b0; alloc_valid = '0; alloc_wen = '0; wb_valid = '0; wb_exc = '0;
  endtask

  task automatic alloc2(input logic [1:0] v, input logic [4:0] rd0, input logic [4:0] rd1,
                        input logic [63:0] pc0, input logic [63:0] pc1);
    alloc_valid = v; alloc_rd = {rd1, rd0}; alloc_pc = {pc1, pc0}; alloc_wen = 2'b11;
  endtask

  task automatic wb(input int port, input logic [3:0] idx, input logic [63:0] data, input logic exc);
    wb_valid[port] = 1'b1; wb_idx[port*4 +: 4] = idx;
    wb_data[port*64 +: 64] = data; wb_exc[port] = exc;
  endtask

  task automatic tick();
    @(negedge clk);
    idle();
  endtask

  task automatic look();
    #2;
  endtask

  initial begin
    int r;
    logic [3:0] ridx;
    idle();
    @(negedge clk); look();
    chk("reset_count", count, 64'd0);
    chk("reset_ready", alloc_ready, 64'd1);
    chk("reset_commit", commit_valid, 64'd0);
    chk("reset_flush", flush_out, 64'd0);
    chk("reset_redirect", redirect_pc, 64'd0);
    chk("reset_epc", epc, 64'd0);
    @(negedge clk); rst = 1'b0;

    // Fill with no writebacks: 16 entries, ninth group refused.
    for (int g = 0; g < 8; g++) begin
      tick(); alloc2(2'b11, 5'(2*g), 5'(2*g+1), 64'h1000 + 64'(g), 64'h2000 + 64'(g));
      if (g == 0) begin look(); chk("fill_first_idx", alloc_idx, 64'h10); end
    end
    tick(); alloc2(2'b11, 5'd1, 5'd2, 64'h0, 64'h0); look();
    chk("fill_count", count, 64'd16);
    chk("fill_ready", alloc_ready, 64'd0);
    chk("fill_idx", alloc_idx, 64'h10);
    tick(); look(); chk("fill_ninth_ignored", count, 64'd16);
    tick(); flush_in = 1'b1;
    tick(); look(); chk("fill_flush_count", count, 64'd0); chk("fill_no_oflush", flush_out, 64'd0);

    // Out-of-order writeback over entries 0..3.
    tick(); alloc2(2'b11, 5'd10, 5'd11, 64'h0, 64'h0);
    tick(); alloc2(2'b11, 5'd12, 5'd13, 64'h0, 64'h0);
    tick(); wb(0, 4'd3, D + 64'd3, 1'b0); look(); chk("ooo_wait_a", commit_valid, 64'd0);
    tick(); wb(0, 4'd1, D + 64'd1, 1'b0); look(); chk("ooo_wait_b", commit_valid, 64'd0);
    tick(); wb(0, 4'd0, D + 64'd0, 1'b0); look(); chk("ooo_wait_c", commit_valid, 64'd0);
    tick(); look();
    chk("ooo_retire01", commit_valid, 64'd3);
    chk("ooo_rd01", commit_rd, {5'd11, 5'd10});
    chk("ooo_data0", commit_data[63:0], D);
    tick(); wb(0, 4'd2, D + 64'd2, 1'b0); look();
    chk("ooo_idx2_blocks", commit_valid, 64'd0); chk("ooo_count2", count, 64'd2);
    tick(); look(); chk("ooo_retire23", commit_valid, 64'd3); chk("ooo_rd23", commit_rd, {5'd13, 5'd12});
    tick(); look(); chk("ooo_empty", count, 64'd0); chk("ooo_tail_idx", alloc_idx, 64'h54);

    // Wrap-around from head=tail=14.
    for (int g = 0; g < 5; g++) begin tick(); alloc2(2'b11, 5'd0, 5'd0, 64'h0, 64'h0); end
    tick(); flush_in = 1'b1;
    tick(); alloc2(2'b11, 5'd20, 5'd21, 64'h0, 64'h0); look(); chk("wrap_idx_a", alloc_idx, 64'hFE);
    tick(); alloc2(2'b11, 5'd22, 5'd23, 64'h0, 64'h0); look(); chk("wrap_idx_b", alloc_idx, 64'h10);
    tick(); wb(0, 4'd14, D + 64'd14, 1'b0); wb(1, 4'd15, D + 64'd15, 1'b0);
    tick(); wb(0, 4'd0, D + 64'd16, 1'b0); wb(1, 4'd1, D + 64'd17, 1'b0); look();
    chk("wrap_retire_a", commit_valid, 64'd3); chk("wrap_rd_a", commit_rd, {5'd21, 5'd20});
    tick(); look(); chk("wrap_retire_b", commit_valid, 64'd3); chk("wrap_rd_b", commit_rd, {5'd23, 5'd22});
    tick(); look(); chk("wrap_empty", count, 64'd0);

    // Exception at idx6 with idx5 retiring in front of it.
    tick(); alloc2(2'b11, 5'd0, 5'd0, 64'h0, 64'h0);
    tick(); alloc2(2'b01, 5'd0, 5'd0, 64'h0, 64'h0);
    tick(); flush_in = 1'b1;
    tick(); alloc2(2'b11, 5'd5, 5'd6, 64'h8000_0030, 64'h8000_0040);
    tick(); alloc2(2'b01, 5'd7, 5'd0, 64'h8000_0050, 64'h0);
    tick(); wb(0, 4'd7, D + 64'd7, 1'b0);
    tick(); wb(0, 4'd5, D + 64'd5, 1'b0); wb(1, 4'd6, D + 64'd6, 1'b1);
    tick(); look();
    chk("exc_retire_idx5", commit_valid, 64'd1); chk("exc_rd5", commit_rd[4:0], 64'd5);
    chk("exc_data5", commit_data[63:0], D + 64'd5); chk("exc_no_flush_yet", flush_out, 64'd0);
    tick(); alloc2(2'b11, 5'd0, 5'd0, 64'h0, 64'h0); look();
    chk("exc_flush", flush_out, 64'd1); chk("exc_redirect", redirect_pc, 64'h100);
    chk("exc_epc", epc, 64'h8000_0040); chk("exc_count", count, 64'd0);
    tick(); look(); chk("exc_alloc_blocked", count, 64'd0); chk("exc_tail_idx", alloc_idx, 64'h98);

    // External flush with a pending retire and a pending fault.
    for (int g = 0; g < 3; g++) begin tick(); alloc2(2'b11, 5'd1, 5'd2, 64'h0, 64'h0); end
    tick(); wb(0, 4'd8, D, 1'b0); wb(1, 4'd9, D, 1'b1);
    tick(); flush_in = 1'b1; alloc2(2'b11, 5'd3, 5'd4, 64'h0, 64'h0); wb(0, 4'd10, D, 1'b0); look();
    chk("xflush_no_commit", commit_valid, 64'd0); chk("xflush_count_before", count, 64'd6);
    tick(); look(); chk("xflush_count", count, 64'd0); chk("xflush_no_oflush", flush_out, 64'd0);

    // Asynchronous reset between edges with 10 entries in flight.
    for (int g = 0; g < 5; g++) begin tick(); alloc2(2'b11, 5'd1, 5'd2, 64'h0, 64'h0); end
    tick(); wb(0, 4'd14, D, 1'b0); wb(1, 4'd15, D, 1'b0);
    tick(); look(); chk("areset_pre_commit", commit_valid, 64'd3); chk("areset_pre_count", count, 64'd10);
    #1 rst = 1'b1;
    #1;
    chk("areset_count", count, 64'd0); chk("areset_commit", commit_valid, 64'd0);
    chk("areset_ready", alloc_ready, 64'd1);
    tick();
    tick(); rst = 1'b0; look(); chk("areset_idx", alloc_idx, 64'h10);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      tick();
      flush_in = ($urandom_range(0, 99) == 0);
      r = $urandom_range(0, 3);
      alloc_valid = (r == 0) ? 2'b00 : ((r == 1) ? 2'b01 : 2'b11);
      alloc_pc = {$urandom, $urandom, $urandom, $urandom};
      alloc_rd = 10'($urandom);
      alloc_wen = 2'($urandom);
      for (int p = 0; p < 2; p++) begin
        if ($urandom_range(0, 9) < 6) begin
          if (q.size() > 0 && $urandom_range(0, 4) != 0) ridx = 4'(q[$urandom_range(0, q.size() - 1)].idx);
          else ridx = 4'($urandom_range(0, 15));
          wb(p, ridx, {$urandom, $urandom}, $urandom_range(0, 29) == 0);
        end
      end
      if (wb_valid[0] && $urandom_range(0, 9) == 0)
        wb(1, wb_idx[3:0], {$urandom, $urandom}, $urandom_range(0, 3) == 0);
    end
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
